reservoir_node_sched: RTL and testbench
=======================================

# reservoir_node_sched

Time-division scheduler for the delay-based reservoir's shared binary input multiplexer. For each accepted input sample it steps through N_NODES virtual nodes. For each node it drives the mux select with that node's input-mask bit for HOLD cycles, then strobes the node as complete. It sits between the sample source (valid/ready) and the mux/nonlinear-node datapath, replacing a free-running select with a sequenced, maskable one.

## Interface
- N_NODES, 16: virtual nodes per sample; must be ≥ 2.
- HOLD, 2: clock cycles per virtual node; must be ≥ 1.
- MASK, 16'hA5C3: input mask; bit k is the select value for node k. Width is N_NODES.
- DATA_W, 8: sample width.
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  a sample is offered on in_data.
- in_data  in  DATA_W  sample value.
- in_ready  out  1  block can accept; = (state==IDLE) && !abort.
- abort  in  1  synchronous cancel of the current sample.
- sel  out  1  mux select for the current node (registered).
- sample  out  DATA_W  latched sample, held stable for the whole sample period.
- node_idx  out  $clog2(N_NODES)  current virtual node index.
- node_valid  out  1  one-cycle strobe on the last hold cycle of each node.
- busy  out  1  high in RUN.
- done  out  1  one-cycle strobe after the last node of a sample.

## Operation
- States:
  - IDLE: waits for a handshake.
  - RUN: steps through the nodes.
  - DONE: single cycle, then back to IDLE.
- Handshake: a sample is accepted when in_valid && in_ready are high at a clock edge. On acceptance, latch in_data into sample, set node_idx=0, hold_cnt=0, sel=MASK[0], and go to RUN.
- RUN:
  - hold_cnt increments each cycle.
  - When hold_cnt==HOLD-1, assert node_valid.
  - On that same edge, if node_idx<N_NODES-1: node_idx+1, hold_cnt=0, sel=MASK[node_idx+1].
  - If node_idx==N_NODES-1 instead: go to DONE, sel=0.
- DONE: done=1 for exactly one cycle; node_idx returns to 0; then IDLE.
- abort:
  - In RUN or DONE, the next state is IDLE with sel=0, node_idx=0, and no done strobe. A node_valid already asserted in the abort cycle stands.
  - In IDLE, abort only blocks acceptance.
- in_valid outside IDLE is ignored and nothing is queued. The sample register changes only on acceptance.
- Counter rule: node_idx and hold_cnt never exceed N_NODES-1 and HOLD-1 respectively, and both wrap to 0 only through the transitions above.
- HOLD==1: node_valid is high on every RUN cycle.

## Timing
- Reset (async assert): state=IDLE, sel=0, sample=0, node_idx=0, hold_cnt=0, node_valid=0, busy=0, done=0. in_ready=1 once rst_n is high and abort is low.
- Acceptance at edge T:
  - busy=1 and sel=MASK[0] from cycle T+1.
  - Node k occupies cycles T+1+k·HOLD through T+(k+1)·HOLD.
  - node_valid fires in cycle T+(k+1)·HOLD.
  - done fires in cycle T+1+N_NODES·HOLD.
  - in_ready is high again in cycle T+2+N_NODES·HOLD.
- Throughput: one sample per N_NODES·HOLD+2 cycles.
- Output registration: all outputs are registered except in_ready, which is combinational from state and abort.
- Reset mid-run: everything clears immediately; no done strobe.

## Structure
- Package reservoir_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default constants for N_NODES, HOLD and MASK;
  - a NODE_W = $clog2(N_NODES) helper.
- One sub-module, vnode_counter, holds the hold_cnt/node_idx pair. It has inputs clear and step, and outputs node_idx, node_last and hold_last.
- The FSM, sample register and sel register live in the top module.

## Test plan
- Basic run: N_NODES=4, HOLD=2, MASK=4'b1010, accept in_data=8'h5A at T.
  - sel=0,0,1,1,0,0,1,1 over T+1..T+8.
  - node_valid at T+2, T+4, T+6, T+8.
  - done at T+9; in_ready high at T+10; sample=8'h5A throughout.
- HOLD=1, N_NODES=4: node_valid high on T+1..T+4; node_idx=0,1,2,3; done at T+5.
- Abort: abort asserted at T+5 of the basic run → IDLE at T+6, sel=0, node_idx=0, no done; a new sample is accepted at T+6.
- Back-to-back: in_valid held high with changing data → second acceptance exactly at T+10. in_valid pulses during RUN are dropped and sample is unchanged.
- Reset mid-run: rst_n low at T+3 (between edges) → all outputs are reset values immediately; after release, the next sample runs from node 0.
- Abort with in_valid in IDLE: in_ready=0 and no acceptance; acceptance occurs on the first edge after abort drops.

Source files
------------

// File: rtl/reservoir_node_sched_pkg.sv
// Shared types and default constants for the reservoir node scheduler.
// Holds the scheduler state enum, default geometry (nodes, hold, mask, width)
// and the node-index width helper used by the top and the counter.
package reservoir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          N_NODES_DEF = 16;
  localparam int          HOLD_DEF    = 2;
  localparam logic [15:0] MASK_DEF    = 16'hA5C3;
  localparam int          DATA_W_DEF  = 8;

  // Width of a node index; at least one bit so a port can always be declared.
  function automatic int node_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NODE_W = node_w(N_NODES_DEF);

endpackage

// File: rtl/reservoir_node_sched_vnode_counter.sv
// Purpose: hold-cycle / virtual-node counter pair for the node scheduler.
// Latency: registered counters; last/pre flags decode the current count.
// Backpressure: none; counts only while step is high, clear has priority.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_clear           force both counters to 0
//   i_step            advance hold count; roll into the next node on last hold
//   o_node_idx        current node index
//   o_node_last       node index is N_NODES-1
//   o_hold_last       hold count is HOLD-1
//   o_hold_pre        hold count is HOLD-2 (next cycle is the last hold cycle)
module vnode_counter
  import reservoir_pkg::*;
#(
  parameter int N_NODES = N_NODES_DEF,
  parameter int HOLD    = HOLD_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clear,
  input  logic                       i_step,
  output logic [$clog2(N_NODES)-1:0] o_node_idx,
  output logic                       o_node_last,
  output logic                       o_hold_last,
  output logic                       o_hold_pre
);

  localparam int NW = $clog2(N_NODES);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD - 1);
  localparam logic [HW-1:0] HOLD_PRE = HW'((HOLD > 1) ? HOLD - 2 : 0);
  localparam logic [NW-1:0] NODE_MAX = NW'(N_NODES - 1);

  logic [HW-1:0] r_hold_cnt;
  logic [NW-1:0] r_node_idx;

  assign o_node_idx  = r_node_idx;
  assign o_node_last = (r_node_idx == NODE_MAX);
  assign o_hold_last = (r_hold_cnt == HOLD_MAX);
  // With HOLD==1 this flag is meaningless; the caller gives hold_last priority.
  assign o_hold_pre  = (r_hold_cnt == HOLD_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
      r_node_idx <= '0;
    end else if (i_clear) begin
      r_hold_cnt <= '0;
      r_node_idx <= '0;
    end else if (i_step) begin
      if (o_hold_last) begin
        r_hold_cnt <= '0;
        // Wrapping past the last node returns the index to 0 for the DONE cycle.
        r_node_idx <= o_node_last ? '0 : r_node_idx + NW'(1);
      end else begin
        r_hold_cnt <= r_hold_cnt + HW'(1);
      end
    end
  end

endmodule

// File: rtl/reservoir_node_sched.sv
// Purpose: time-division scheduler driving the reservoir input mux select per virtual node.
// Latency: outputs start the cycle after acceptance; one sample per N_NODES*HOLD+2 cycles.
// Backpressure: in_ready only in IDLE with abort low; in_valid elsewhere is dropped.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_in_valid/i_in_data/o_in_ready   sample handshake (ready is combinational)
//   i_abort           synchronous cancel of the running sample / block acceptance
//   o_sel             mux select = MASK bit of the current node
//   o_sample          latched sample, stable for the whole sample period
//   o_node_idx        current virtual node
//   o_node_valid      strobe on the last hold cycle of each node
//   o_busy            high while stepping nodes
//   o_done            strobe the cycle after the last node
module reservoir_node_sched
  import reservoir_pkg::*;
#(
  parameter int                 N_NODES = N_NODES_DEF,
  parameter int                 HOLD    = HOLD_DEF,
  parameter logic [N_NODES-1:0] MASK    = N_NODES'(MASK_DEF),
  parameter int                 DATA_W  = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_in_valid,
  input  logic [DATA_W-1:0]          i_in_data,
  output logic                       o_in_ready,
  input  logic                       i_abort,
  output logic                       o_sel,
  output logic [DATA_W-1:0]          o_sample,
  output logic [$clog2(N_NODES)-1:0] o_node_idx,
  output logic                       o_node_valid,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int NW = $clog2(N_NODES);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_sel;
  logic              w_sel_nxt;
  logic              r_node_valid;
  logic              w_nv_nxt;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_sample;
  logic              w_accept;

  logic [NW-1:0]     w_node_idx;
  logic [NW-1:0]     w_node_inc;
  logic              w_node_last;
  logic              w_hold_last;
  logic              w_hold_pre;
  logic              w_cnt_clear;
  logic              w_cnt_step;

  // Counter is parked at 0 outside RUN, so acceptance needs no explicit load.
  assign w_cnt_step  = (r_state == RUN);
  assign w_cnt_clear = (r_state != RUN) || i_abort;
  assign w_node_inc  = w_node_idx + NW'(1);

  vnode_counter #(
    .N_NODES (N_NODES),
    .HOLD    (HOLD)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_cnt_clear),
    .i_step      (w_cnt_step),
    .o_node_idx  (w_node_idx),
    .o_node_last (w_node_last),
    .o_hold_last (w_hold_last),
    .o_hold_pre  (w_hold_pre)
  );

  assign o_in_ready = (r_state == IDLE) && !i_abort;
  assign w_accept   = i_in_valid && o_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the next values of the registered sel / node_valid, so
  // both line up with the node the counter will hold in the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = 1'b0;
    w_nv_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = RUN;
          w_sel_nxt   = MASK[0];
          w_nv_nxt    = (HOLD == 1);
        end
      end
      RUN: begin
        if (i_abort) begin
          w_state_nxt = IDLE;
        end else if (w_hold_last && w_node_last) begin
          w_state_nxt = DONE;
        end else if (w_hold_last) begin
          w_sel_nxt = MASK[w_node_inc];
          w_nv_nxt  = (HOLD == 1);
        end else begin
          w_sel_nxt = r_sel;
          w_nv_nxt  = w_hold_pre;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel        <= 1'b0;
      r_node_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sample     <= '0;
    end else begin
      r_sel        <= w_sel_nxt;
      r_node_valid <= w_nv_nxt;
      r_busy       <= (w_state_nxt == RUN);
      r_done       <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_sample <= i_in_data;
      end
    end
  end

  assign o_sel        = r_sel;
  assign o_sample     = r_sample;
  assign o_node_idx   = w_node_idx;
  assign o_node_valid = r_node_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_reservoir_node_sched.sv
// Bench for reservoir_node_sched: two instances (HOLD=2 and HOLD=1, 4 nodes,
// mask 4'b1010) share stimulus; directed scenarios plus a randomized run
// checked against a per-sample timeline model.
module tb_reservoir_node_sched;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       a_rdy, a_sel, a_nv, a_busy, a_done;
  logic [7:0] a_samp;
  logic [1:0] a_idx;
  logic       b_rdy, b_sel, b_nv, b_busy, b_done;
  logic [7:0] b_samp;
  logic [1:0] b_idx;

  logic [3:0] mask_v = 4'b1010;
  logic [7:0] sel_tab = 8'b11001100;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Model: a sample accepted at edge t0 is in cycle c = cyc - t0 (c=1 first RUN cycle).
  bit         m_act [2];
  int         m_t0  [2];
  logic [7:0] m_samp[2];

  logic       g_sel, g_nv, g_busy, g_done, g_rdy;
  logic [1:0] g_idx;
  logic [7:0] g_samp;
  logic       e_sel, e_nv, e_busy, e_done, e_rdy;
  logic [1:0] e_idx;

  always #5 clk = ~clk;

  reservoir_node_sched #(.N_NODES(4), .HOLD(2), .MASK(4'b1010), .DATA_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(a_rdy), .i_abort(abort), .o_sel(a_sel), .o_sample(a_samp),
    .o_node_idx(a_idx), .o_node_valid(a_nv), .o_busy(a_busy), .o_done(a_done)
  );

  reservoir_node_sched #(.N_NODES(4), .HOLD(1), .MASK(4'b1010), .DATA_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(b_rdy), .i_abort(abort), .o_sel(b_sel), .o_sample(b_samp),
    .o_node_idx(b_idx), .o_node_valid(b_nv), .o_busy(b_busy), .o_done(b_done)
  );

  function automatic int hd(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic bit m_idle(input int d, input int cy);
    return !m_act[d] || ((cy - m_t0[d]) >= N * hd(d) + 2);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d]  = 1'b0;
      m_t0[d]   = 0;
      m_samp[d] = 8'h00;
    end
  endtask

  // One clock edge: update the model with the inputs seen at the edge, then
  // step 1 time unit past the edge before anyone samples.
  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (m_idle(d, cyc)) begin
        if (in_valid && !abort) begin
          m_act[d]  = 1'b1;
          m_t0[d]   = cyc;
          m_samp[d] = in_data;
        end else begin
          m_act[d] = 1'b0;
        end
      end else if (abort) begin
        m_act[d] = 1'b0;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    abort    = 1'b0;
    for (int i = 0; i < 40 && !(m_idle(0, cyc) && m_idle(1, cyc)); i++) tick();
    tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    n_chk++; if (a_sel !== 1'b0)   $display("FAIL reset_sel got=%b exp=0", a_sel); else n_pass++;
    n_chk++; if (a_idx !== 2'd0)   $display("FAIL reset_idx got=%0d exp=0", a_idx); else n_pass++;
    n_chk++; if (a_nv !== 1'b0)    $display("FAIL reset_nv got=%b exp=0", a_nv); else n_pass++;
    n_chk++; if (a_busy !== 1'b0)  $display("FAIL reset_busy got=%b exp=0", a_busy); else n_pass++;
    n_chk++; if (a_done !== 1'b0)  $display("FAIL reset_done got=%b exp=0", a_done); else n_pass++;
    n_chk++; if (a_samp !== 8'h00) $display("FAIL reset_sample got=%h exp=00", a_samp); else n_pass++;
    n_chk++; if (b_busy !== 1'b0)  $display("FAIL reset_b_busy got=%b exp=0", b_busy); else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if (a_rdy !== 1'b1)   $display("FAIL reset_ready got=%b exp=1", a_rdy); else n_pass++;
  endtask

  task automatic test_basic();
    drain();
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0; in_data = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      e_sel  = (c <= 8) ? sel_tab[c-1] : 1'b0;
      e_nv   = (c <= 8) && (c % 2 == 0);
      e_busy = (c <= 8);
      e_done = (c == 9);
      e_idx  = (c <= 8) ? 2'((c - 1) / 2) : 2'd0;
      e_rdy  = (c >= 10);
      n_chk++; if (a_sel !== e_sel)   $display("FAIL basic_sel c=%0d got=%b exp=%b", c, a_sel, e_sel); else n_pass++;
      n_chk++; if (a_nv !== e_nv)     $display("FAIL basic_nv c=%0d got=%b exp=%b", c, a_nv, e_nv); else n_pass++;
      n_chk++; if (a_busy !== e_busy) $display("FAIL basic_busy c=%0d got=%b exp=%b", c, a_busy, e_busy); else n_pass++;
      n_chk++; if (a_done !== e_done) $display("FAIL basic_done c=%0d got=%b exp=%b", c, a_done, e_done); else n_pass++;
      n_chk++; if (a_idx !== e_idx)   $display("FAIL basic_idx c=%0d got=%0d exp=%0d", c, a_idx, e_idx); else n_pass++;
      n_chk++; if (a_rdy !== e_rdy)   $display("FAIL basic_ready c=%0d got=%b exp=%b", c, a_rdy, e_rdy); else n_pass++;
      n_chk++; if (a_samp !== 8'h5A)  $display("FAIL basic_sample c=%0d got=%h exp=5a", c, a_samp); else n_pass++;
      tick();
    end
  endtask

  task automatic test_hold1();
    drain();
    in_valid = 1'b1; in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      e_nv   = (c <= 4);
      e_idx  = (c <= 4) ? 2'(c - 1) : 2'd0;
      e_done = (c == 5);
      e_sel  = (c <= 4) ? mask_v[c-1] : 1'b0;
      e_rdy  = (c >= 6);
      n_chk++; if (b_nv !== e_nv)     $display("FAIL hold1_nv c=%0d got=%b exp=%b", c, b_nv, e_nv); else n_pass++;
      n_chk++; if (b_idx !== e_idx)   $display("FAIL hold1_idx c=%0d got=%0d exp=%0d", c, b_idx, e_idx); else n_pass++;
      n_chk++; if (b_done !== e_done) $display("FAIL hold1_done c=%0d got=%b exp=%b", c, b_done, e_done); else n_pass++;
      n_chk++; if (b_sel !== e_sel)   $display("FAIL hold1_sel c=%0d got=%b exp=%b", c, b_sel, e_sel); else n_pass++;
      n_chk++; if (b_rdy !== e_rdy)   $display("FAIL hold1_ready c=%0d got=%b exp=%b", c, b_rdy, e_rdy); else n_pass++;
      tick();
    end
  endtask

  task automatic test_abort();
    drain();
    in_valid = 1'b1; in_data = 8'hA7;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    #1;
    n_chk++; if (a_rdy !== 1'b0) $display("FAIL abort_ready_run got=%b exp=0", a_rdy); else n_pass++;
    tick();
    n_chk++; if (a_busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", a_busy); else n_pass++;
    n_chk++; if (a_sel !== 1'b0)  $display("FAIL abort_sel got=%b exp=0", a_sel); else n_pass++;
    n_chk++; if (a_idx !== 2'd0)  $display("FAIL abort_idx got=%0d exp=0", a_idx); else n_pass++;
    n_chk++; if (a_done !== 1'b0) $display("FAIL abort_done got=%b exp=0", a_done); else n_pass++;
    abort = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
    #1;
    n_chk++; if (a_rdy !== 1'b1) $display("FAIL abort_ready_idle got=%b exp=1", a_rdy); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_chk++; if (a_busy !== 1'b1)  $display("FAIL abort_reaccept_busy got=%b exp=1", a_busy); else n_pass++;
    n_chk++; if (a_samp !== 8'h3C) $display("FAIL abort_reaccept_sample got=%h exp=3c", a_samp); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d0;
    logic [7:0] d1;
    drain();
    d0 = 8'($urandom);
    in_valid = 1'b1; in_data = d0;
    tick();
    d1 = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      n_chk++; if (a_samp !== d0) $display("FAIL b2b_sample c=%0d got=%h exp=%h", c, a_samp, d0); else n_pass++;
      n_chk++; if (a_rdy !== (c == 10)) $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, a_rdy, (c == 10)); else n_pass++;
      d1 = 8'($urandom);
      in_data = d1;
      tick();
    end
    in_valid = 1'b0;
    n_chk++; if (a_busy !== 1'b1) $display("FAIL b2b_second_busy got=%b exp=1", a_busy); else n_pass++;
    n_chk++; if (a_samp !== d1)   $display("FAIL b2b_second_sample got=%h exp=%h", a_samp, d1); else n_pass++;
    n_chk++; if (a_idx !== 2'd0)  $display("FAIL b2b_second_idx got=%0d exp=0", a_idx); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    drain();
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (a_busy !== 1'b0)  $display("FAIL rstmid_busy got=%b exp=0", a_busy); else n_pass++;
    n_chk++; if (a_sel !== 1'b0)   $display("FAIL rstmid_sel got=%b exp=0", a_sel); else n_pass++;
    n_chk++; if (a_idx !== 2'd0)   $display("FAIL rstmid_idx got=%0d exp=0", a_idx); else n_pass++;
    n_chk++; if (a_samp !== 8'h00) $display("FAIL rstmid_sample got=%h exp=00", a_samp); else n_pass++;
    n_chk++; if (a_done !== 1'b0)  $display("FAIL rstmid_done got=%b exp=0", a_done); else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'h99;
    tick();
    in_valid = 1'b0;
    n_chk++; if (a_busy !== 1'b1)  $display("FAIL rstmid_restart_busy got=%b exp=1", a_busy); else n_pass++;
    n_chk++; if (a_idx !== 2'd0)   $display("FAIL rstmid_restart_idx got=%0d exp=0", a_idx); else n_pass++;
    n_chk++; if (a_samp !== 8'h99) $display("FAIL rstmid_restart_sample got=%h exp=99", a_samp); else n_pass++;
  endtask

  task automatic test_abort_idle();
    drain();
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h42;
    #1;
    n_chk++; if (a_rdy !== 1'b0) $display("FAIL abidle_ready got=%b exp=0", a_rdy); else n_pass++;
    repeat (2) begin
      tick();
      n_chk++; if (a_busy !== 1'b0) $display("FAIL abidle_busy got=%b exp=0", a_busy); else n_pass++;
      n_chk++; if (a_samp !== m_samp[0]) $display("FAIL abidle_sample got=%h exp=%h", a_samp, m_samp[0]); else n_pass++;
    end
    abort = 1'b0;
    #1;
    n_chk++; if (a_rdy !== 1'b1) $display("FAIL abidle_ready_drop got=%b exp=1", a_rdy); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_chk++; if (a_busy !== 1'b1)  $display("FAIL abidle_accept_busy got=%b exp=1", a_busy); else n_pass++;
    n_chk++; if (a_samp !== 8'h42) $display("FAIL abidle_accept_sample got=%h exp=42", a_samp); else n_pass++;
  endtask

  task automatic test_random();
    drain();
    for (int i = 0; i < 800; i++) begin
      for (int d = 0; d < 2; d++) begin
        int c;
        int hh;
        int k;
        hh = hd(d);
        c  = cyc - m_t0[d];
        e_busy = m_act[d] && (c >= 1) && (c <= N * hh);
        k      = e_busy ? (c - 1) / hh : 0;
        e_sel  = e_busy ? mask_v[k] : 1'b0;
        e_idx  = 2'(k);
        e_nv   = e_busy && (c % hh == 0);
        e_done = m_act[d] && (c == N * hh + 1);
        g_sel  = (d == 0) ? a_sel  : b_sel;
        g_nv   = (d == 0) ? a_nv   : b_nv;
        g_busy = (d == 0) ? a_busy : b_busy;
        g_done = (d == 0) ? a_done : b_done;
        g_idx  = (d == 0) ? a_idx  : b_idx;
        g_samp = (d == 0) ? a_samp : b_samp;
        n_chk++; if (g_sel !== e_sel)   $display("FAIL rnd_sel d=%0d cyc=%0d got=%b exp=%b", d, cyc, g_sel, e_sel); else n_pass++;
        n_chk++; if (g_nv !== e_nv)     $display("FAIL rnd_nv d=%0d cyc=%0d got=%b exp=%b", d, cyc, g_nv, e_nv); else n_pass++;
        n_chk++; if (g_busy !== e_busy) $display("FAIL rnd_busy d=%0d cyc=%0d got=%b exp=%b", d, cyc, g_busy, e_busy); else n_pass++;
        n_chk++; if (g_done !== e_done) $display("FAIL rnd_done d=%0d cyc=%0d got=%b exp=%b", d, cyc, g_done, e_done); else n_pass++;
        n_chk++; if (g_idx !== e_idx)   $display("FAIL rnd_idx d=%0d cyc=%0d got=%0d exp=%0d", d, cyc, g_idx, e_idx); else n_pass++;
        n_chk++; if (g_samp !== m_samp[d]) $display("FAIL rnd_sample d=%0d cyc=%0d got=%h exp=%h", d, cyc, g_samp, m_samp[d]); else n_pass++;
      end
      in_valid = 1'($urandom_range(0, 1));
      abort    = ($urandom_range(0, 15) == 0);
      in_data  = 8'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        e_rdy = m_idle(d, cyc) && !abort;
        g_rdy = (d == 0) ? a_rdy : b_rdy;
        n_chk++; if (g_rdy !== e_rdy) $display("FAIL rnd_ready d=%0d cyc=%0d got=%b exp=%b", d, cyc, g_rdy, e_rdy); else n_pass++;
      end
      tick();
    end
    in_valid = 1'b0;
    abort    = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_hold1();
    test_abort();
    test_back_to_back();
    test_reset_midrun();
    test_abort_idle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
